// File: rtl/ahb_register_slave_if.sv
// AHB-Lite bus bundle between the CPU-side master and the endpoint register slave.
interface ahb_register_slave_if;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hwdata,
    input  hrdata, hresp, hready
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hwdata,
    output hrdata, hresp, hready
  );
endinterface

// File: rtl/ahb_register_slave.sv
// AHB-Lite slave exposing the USB endpoint value registers and data-buffer strobes.
// Optional feature macro: AHB_ALIGN_CHECK_EN (misaligned accesses get an ERROR
// response; when undefined the low address bits below the access size are dropped).
module ahb_register_slave (
  input  logic                clk,
  input  logic                rst,
  ahb_register_slave_if.slave bus,
  input  logic [15:0]         statusData,
  input  logic [15:0]         errorData,
  input  logic [7:0]          boData,
  input  logic [7:0]          ehtsData,
  input  logic [31:0]         rxData,
  input  logic                txDone,
  input  logic                bufferCleared,
  output logic                getRxData,
  output logic                storeTxData,
  output logic [31:0]         txData,
  output logic [1:0]          dataSize,
  output logic [7:0]          txPacketDataSize,
  output logic                clearBuffer
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  localparam logic [3:0] TXCTRL_ADDR = 4'hC;
  localparam logic [3:0] FLUSH_ADDR  = 4'hD;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DATA     = 3'd1;
  localparam logic [2:0] S_BUF_WAIT = 3'd2;
  localparam logic [2:0] S_BUF_RD   = 3'd3;
  localparam logic [2:0] S_ERR1     = 3'd4;
  localparam logic [2:0] S_ERR2     = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt, aaddr;
  logic [1:0]        size_q, size_nxt, dsize_nxt;
  logic              write_q, write_nxt;
  logic              hready_q, hready_nxt, hresp_q, hresp_nxt;
  logic              get_nxt, store_nxt, accept;
  logic              misalign, is_buf, is_ro, is_bad, addr_err;
  logic [3:0]        be;
  logic [DATA_W-1:0] wlane, rword, rlane, rsel, hrdata_c;
  logic              reg_wr, flush_nxt;
  logic [7:0]        txctrl_nxt;
  logic              unused;

  assign unused     = bus.htrans[0];
  assign txData     = bus.hwdata;
  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;
  assign bus.hrdata = hrdata_c;

  // Address-phase decode: effective address and legality of the new transfer
  always_comb begin
    misalign = 1'b0;
    aaddr    = bus.haddr;
`ifdef AHB_ALIGN_CHECK_EN
    case (bus.hsize)
      2'd1:    misalign = bus.haddr[0];
      2'd2:    misalign = (bus.haddr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    case (bus.hsize)
      2'd0:    aaddr = bus.haddr;
      2'd1:    aaddr = {bus.haddr[3:1], 1'b0};
      default: aaddr = {bus.haddr[3:2], 2'b00};
    endcase
`endif
    is_buf   = (aaddr[3:2] == 2'b00);
    is_ro    = (aaddr[3:2] == 2'b01) || (aaddr[3:2] == 2'b10);
    is_bad   = (aaddr[3:1] == 3'b111);
    // flush_nxt so a buffer access right behind a flush write is already refused
    addr_err = misalign || is_bad || (bus.hwrite && is_ro) || (is_buf && flush_nxt);
  end

  // Data-phase register writes; a bus write beats a same-cycle hardware clear
  always_comb begin
    case (size_q)
      2'd0:    be = 4'(4'b0001 << addr_q[1:0]);
      2'd1:    be = 4'(4'b0011 << addr_q[1:0]);
      default: be = 4'b1111;
    endcase
    wlane      = bus.hwdata << {addr_q[1:0], 3'b000};
    reg_wr     = (state == S_DATA) && write_q && (addr_q[3:2] == TXCTRL_ADDR[3:2]);
    txctrl_nxt = txPacketDataSize;
    flush_nxt  = clearBuffer;
    if (txDone)        txctrl_nxt = 8'h00;
    if (bufferCleared) flush_nxt  = 1'b0;
    if (reg_wr && be[TXCTRL_ADDR[1:0]]) txctrl_nxt = wlane[{TXCTRL_ADDR[1:0], 3'b000} +: 8];
    if (reg_wr && be[FLUSH_ADDR[1:0]])  flush_nxt  = wlane[{FLUSH_ADDR[1:0], 3'b000}];
  end

  // Read data: select the word, shift the addressed lane down, zero the rest
  always_comb begin
    case (addr_q[3:2])
      2'b00:   rword = rxData;
      2'b01:   rword = {errorData, statusData};
      2'b10:   rword = {8'h00, ehtsData, 8'h00, boData};
      default: rword = {16'h0000, 7'h00, clearBuffer, txPacketDataSize};
    endcase
    rlane = rword >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    rsel = {24'h000000, rlane[7:0]};
      2'd1:    rsel = {16'h0000, rlane[15:0]};
      default: rsel = rlane;
    endcase
    hrdata_c = '0;
    if ((state == S_DATA && !write_q) || state == S_BUF_RD) hrdata_c = rsel;
  end

  // Next-state and registered-output decisions
  always_comb begin
    state_nxt = S_IDLE;
    addr_nxt  = addr_q;
    size_nxt  = size_q;
    write_nxt = write_q;
    get_nxt   = 1'b0;
    store_nxt = 1'b0;
    dsize_nxt = 2'b00;
    accept    = bus.hsel && bus.htrans[1] && hready_q;
    case (state)
      S_BUF_WAIT: state_nxt = S_BUF_RD;
      S_ERR1:     state_nxt = S_ERR2;
      default: begin
        if (accept) begin
          addr_nxt  = aaddr;
          size_nxt  = bus.hsize;
          write_nxt = bus.hwrite;
          if (addr_err) begin
            state_nxt = S_ERR1;
          end else if (is_buf && !bus.hwrite) begin
            state_nxt = S_BUF_WAIT;
            get_nxt   = 1'b1;
            dsize_nxt = bus.hsize;
          end else begin
            state_nxt = S_DATA;
            if (is_buf) begin
              store_nxt = 1'b1;
              dsize_nxt = bus.hsize;
            end
          end
        end
      end
    endcase
    hready_nxt = !((state_nxt == S_BUF_WAIT) || (state_nxt == S_ERR1));
    hresp_nxt  = (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
  end

  // State, captured control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      addr_q           <= '0;
      size_q           <= 2'b00;
      write_q          <= 1'b0;
      hready_q         <= 1'b1;
      hresp_q          <= 1'b0;
      getRxData        <= 1'b0;
      storeTxData      <= 1'b0;
      dataSize         <= 2'b00;
      txPacketDataSize <= 8'h00;
      clearBuffer      <= 1'b0;
    end else begin
      state            <= state_nxt;
      addr_q           <= addr_nxt;
      size_q           <= size_nxt;
      write_q          <= write_nxt;
      hready_q         <= hready_nxt;
      hresp_q          <= hresp_nxt;
      getRxData        <= get_nxt;
      storeTxData      <= store_nxt;
      dataSize         <= dsize_nxt;
      txPacketDataSize <= txctrl_nxt;
      clearBuffer      <= flush_nxt;
    end
  end
endmodule

// File: tb/tb_ahb_register_slave.sv
// Bench for ahb_register_slave: directed steps then random transfers against a byte-map model.
module tb_ahb_register_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_register_slave_if bus();

  logic [15:0] statusData, errorData;
  logic [7:0]  boData, ehtsData;
  logic [31:0] rxData;
  logic        txDone, bufferCleared;
  logic        getRxData, storeTxData;
  logic [31:0] txData;
  logic [1:0]  dataSize;
  logic [7:0]  txPacketDataSize;
  logic        clearBuffer;

  ahb_register_slave dut (
    .clk(clk), .rst(rst), .bus(bus),
    .statusData(statusData), .errorData(errorData), .boData(boData), .ehtsData(ehtsData),
    .rxData(rxData), .txDone(txDone), .bufferCleared(bufferCleared),
    .getRxData(getRxData), .storeTxData(storeTxData), .txData(txData), .dataSize(dataSize),
    .txPacketDataSize(txPacketDataSize), .clearBuffer(clearBuffer)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pop_count = 0;
  int push_count = 0;
  logic [31:0] rx_next = 32'h0;
  logic [31:0] push_data;
  logic [1:0]  push_size;
  logic [7:0]  txctrl_m;
  logic        flush_m;

  // Endpoint FIFO stand-in: pop presents the next word one cycle later
  always @(posedge clk) begin
    if (getRxData === 1'b1) begin
      rxData    <= rx_next;
      pop_count <= pop_count + 1;
    end
    if (storeTxData === 1'b1) begin
      push_count <= push_count + 1;
      push_data  <= txData;
      push_size  <= dataSize;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_align(input logic [3:0] addr, input logic [1:0] size);
    int n = 1 << size;
`ifdef AHB_ALIGN_CHECK_EN
    return addr;
`else
    return 4'((int'(addr) / n) * n);
`endif
  endfunction

  function automatic bit m_misaligned(input logic [3:0] addr, input logic [1:0] size);
`ifdef AHB_ALIGN_CHECK_EN
    return (int'(addr) % (1 << size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [1:0] size);
    logic [7:0]  map [16];
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 16; i++) map[i] = 8'h00;
    for (int i = 0; i < 4; i++) map[i] = rx_next[8*i +: 8];
    map[4]  = statusData[7:0];  map[5] = statusData[15:8];
    map[6]  = errorData[7:0];   map[7] = errorData[15:8];
    map[8]  = boData;           map[10] = ehtsData;
    map[12] = txctrl_m;         map[13] = {7'h00, flush_m};
    for (int i = 0; i < (1 << size); i++)
      if (int'(a) + i < 16) r[8*i +: 8] = map[int'(a) + i];
    return r;
  endfunction

  task automatic bus_idle();
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.haddr = 4'h0; bus.hsize = 2'b00;
  endtask

  task automatic xfer(input logic [3:0] addr, input logic [1:0] size, input logic wr,
                      input logic [31:0] wdata, input bit coincide,
                      output logic [31:0] rdata, output logic fr, output logic lr, output int waits);
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr; bus.hsize = size; bus.hwrite = wr;
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = wdata;
    if (coincide) begin txDone = 1'b1; bufferCleared = 1'b1; end
    fr = bus.hresp;
    waits = 0;
    while (bus.hready !== 1'b1 && waits < 8) begin
      @(posedge clk); #1;
      txDone = 1'b0; bufferCleared = 1'b0;
      waits++;
    end
    rdata = bus.hrdata;
    lr = bus.hresp;
    @(posedge clk); #1;
    txDone = 1'b0; bufferCleared = 1'b0;
  endtask

  task automatic txn(input logic [3:0] addr, input logic [1:0] size, input logic wr,
                     input logic [31:0] wdata, input bit coincide, output logic [31:0] rdata);
    logic [3:0]  a;
    logic [31:0] exp_rd;
    bit err, bufrd, bufwr;
    logic fr, lr;
    int waits, pc0, pu0;
    a      = m_align(addr, size);
    err    = m_misaligned(addr, size) || a >= 14 || (wr && a >= 4 && a <= 11) || (a < 4 && flush_m);
    bufrd  = !err && !wr && a < 4;
    bufwr  = !err && wr && a < 4;
    exp_rd = m_read(a, size);
    pc0 = pop_count; pu0 = push_count;
    xfer(addr, size, wr, wdata, coincide, rdata, fr, lr, waits);
    if (coincide) begin txctrl_m = 8'h00; flush_m = 1'b0; end
    if (!err && wr)
      for (int i = 0; i < (1 << size); i++) begin
        if (int'(a) + i == 12) txctrl_m = wdata[8*i +: 8];
        if (int'(a) + i == 13) flush_m  = wdata[8*i];
      end
    check($sformatf("resp_first@%h/%0d/%0d", addr, size, wr), 32'(fr), 32'(err));
    check($sformatf("resp_last@%h/%0d/%0d", addr, size, wr), 32'(lr), 32'(err));
    check($sformatf("wait_states@%h/%0d/%0d", addr, size, wr), 32'(waits), (err || bufrd) ? 32'd1 : 32'd0);
    if (!wr && !err) check($sformatf("read_data@%h/%0d", addr, size), rdata, exp_rd);
    check($sformatf("pops@%h", addr), 32'(pop_count - pc0), 32'(bufrd));
    check($sformatf("pushes@%h", addr), 32'(push_count - pu0), 32'(bufwr));
    if (bufwr) begin
      check("push_data", push_data, wdata);
      check("push_size", 32'(push_size), 32'(size));
    end
    check("txctrl_reg", 32'(txPacketDataSize), 32'(txctrl_m));
    check("flush_reg", 32'(clearBuffer), 32'(flush_m));
  endtask

  task automatic pulse(input bit done, input bit clr);
    txDone = done; bufferCleared = clr;
    @(posedge clk); #1;
    txDone = 1'b0; bufferCleared = 1'b0;
    if (done) txctrl_m = 8'h00;
    if (clr)  flush_m  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int pc, pu;
    rst = 1'b1;
    bus_idle();
    bus.hwdata = 32'h0;
    statusData = 16'h0; errorData = 16'h0; boData = 8'h0; ehtsData = 8'h0;
    rxData = 32'h0; txDone = 1'b0; bufferCleared = 1'b0;
    txctrl_m = 8'h00; flush_m = 1'b0;

    // reset values, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_hready", 32'(bus.hready), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_strobes", {30'h0, getRxData, storeTxData}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_txctrl", 32'(txPacketDataSize), 32'h0);
    check("post_rst_flush", 32'(clearBuffer), 32'h0);
    check("post_rst_hready", 32'(bus.hready), 32'd1);

    // status halfword read
    statusData = 16'h0201; errorData = 16'hA55A; boData = 8'h3C; ehtsData = 8'hC3;
    txn(4'h4, 2'd1, 1'b0, 32'h0, 1'b0, rd);
    check("status_read", rd, 32'h0000_0201);

    // TX control write then hardware clear
    txn(4'hC, 2'd0, 1'b1, 32'h0000_0040, 1'b0, rd);
    check("txctrl_written", 32'(txPacketDataSize), 32'h40);
    pulse(1'b1, 1'b0);
    check("txctrl_cleared", 32'(txPacketDataSize), 32'h00);

    // buffer word read with one wait state
    rx_next = 32'hDEAD_BEEF;
    txn(4'h0, 2'd2, 1'b0, 32'h0, 1'b0, rd);
    check("buffer_read", rd, 32'hDEAD_BEEF);

    // write to a read-only register, then confirm the path is intact
    errorData = 16'h1234;
    txn(4'h6, 2'd1, 1'b1, 32'h0000_FFFF, 1'b0, rd);
    txn(4'h6, 2'd1, 1'b0, 32'h0, 1'b0, rd);
    check("error_data_intact", rd, 32'h0000_1234);

    // misaligned word read
    rx_next = 32'h0BAD_F00D;
    txn(4'h2, 2'd2, 1'b0, 32'h0, 1'b0, rd);

    // writes beat same-cycle clears
    txn(4'hC, 2'd1, 1'b1, 32'h0000_0155, 1'b1, rd);
    check("coincide_txctrl", 32'(txPacketDataSize), 32'h55);
    check("coincide_flush", 32'(clearBuffer), 32'h1);
    txn(4'hC, 2'd1, 1'b0, 32'h0, 1'b0, rd);
    check("ctrl_half_read", rd, 32'h0000_0155);

    // buffer accesses refused while flushing
    txn(4'h0, 2'd2, 1'b1, 32'h1111_2222, 1'b0, rd);
    txn(4'h1, 2'd0, 1'b0, 32'h0, 1'b0, rd);
    pulse(1'b0, 1'b1);
    txn(4'h0, 2'd2, 1'b1, 32'hCAFE_F00D, 1'b0, rd);
    txn(4'hD, 2'd0, 1'b0, 32'h0, 1'b0, rd);

    // reserved addresses and small RO reads
    txn(4'hE, 2'd0, 1'b0, 32'h0, 1'b0, rd);
    txn(4'hF, 2'd0, 1'b1, 32'hFF, 1'b0, rd);
    txn(4'h8, 2'd0, 1'b0, 32'h0, 1'b0, rd);
    txn(4'hA, 2'd0, 1'b0, 32'h0, 1'b0, rd);
    txn(4'h9, 2'd1, 1'b0, 32'h0, 1'b0, rd);

    // write to TX control immediately followed by its read
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 4'hC; bus.hsize = 2'd0; bus.hwrite = 1'b1;
    @(posedge clk); #1;
    bus.hwdata = 32'h0000_007E;
    bus.hwrite = 1'b0;
    check("pipe_hready", 32'(bus.hready), 32'd1);
    @(posedge clk); #1;
    bus_idle();
    check("pipe_read_new", bus.hrdata, 32'h0000_007E);
    @(posedge clk); #1;
    txctrl_m = 8'h7E;
    check("pipe_txctrl", 32'(txPacketDataSize), 32'h7E);

    // reset during a buffer read wait state
    pulse(1'b0, 1'b1);
    rx_next = 32'h1357_9BDF;
    pc = pop_count; pu = push_count;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 4'h0; bus.hsize = 2'd2; bus.hwrite = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    check("abort_pop_pending", 32'(getRxData), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_hready", 32'(bus.hready), 32'd1);
    check("abort_hresp", 32'(bus.hresp), 32'd0);
    check("abort_no_strobe", 32'(getRxData), 32'd0);
    check("abort_txctrl", 32'(txPacketDataSize), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    txctrl_m = 8'h00; flush_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_pop", 32'(pop_count - pc), 32'd0);
    check("abort_no_push", 32'(push_count - pu), 32'd0);
    rx_next = 32'h2468_ACE0;
    txn(4'h0, 2'd2, 1'b0, 32'h0, 1'b0, rd);

    // random transfers
    for (int k = 0; k < 300; k++) begin
      statusData = 16'($urandom);
      errorData  = 16'($urandom);
      boData     = 8'($urandom);
      ehtsData   = 8'($urandom);
      rx_next    = $urandom;
      if ($urandom_range(0, 7) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      txn(4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
          $urandom, 1'b0, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
